// File: rtl/mux_arb_pkg.sv
// Shared types and the round-robin pick function for the 4-way mux arbiter.
// The pick scans ptr, ptr+1, ptr+2, ptr+3 (mod 4) and returns the first requester found.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan from the farthest offset down, so the nearest requester to ptr wins last.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   ptr);
        pick_t            p;
        logic [SEL_W-1:0] cand;
        p = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux4.sv
// Plain combinational 4:1 mux; the shared datapath the arbiter steers.
module mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared mux4; bursts are capped at MAX_BURST beats per grant,
// and a release re-arbitrates in the same edge so back-to-back grants have no bubble.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [WIDTH-1:0]   in0,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [WIDTH-1:0]   in3,
    input  logic               out_ready,
    output logic [3:0]         gnt,
    output logic [1:0]         sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               busy
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t           r_state, r_state_next;
    logic [SEL_W-1:0]     r_sel, r_sel_next;
    logic [NUM_REQ-1:0]   r_gnt, r_gnt_next;
    logic [SEL_W-1:0]     r_ptr, r_ptr_next;
    logic [CNT_W-1:0]     r_cnt, r_cnt_next;

    logic                 w_busy;
    logic                 w_owner_req;
    logic                 w_valid;
    logic                 w_xfer;
    logic                 w_last;
    logic                 w_release;
    logic [SEL_W-1:0]     w_ptr_after;
    pick_t                w_pick_idle;
    pick_t                w_pick_rel;

    assign w_busy      = (r_state == ST_GRANT);
    assign w_owner_req = req[r_sel];
    assign w_valid     = w_busy & w_owner_req;
    assign w_xfer      = w_valid & out_ready;
    assign w_last      = w_xfer && (r_cnt == LAST_BEAT);
    assign w_release   = w_busy && (!w_owner_req || w_last);
    assign w_ptr_after = r_sel + SEL_W'(1);

    // On release the old owner sits at offset 3 from the new pointer, so it is eligible last.
    assign w_pick_idle = rr_pick(req, r_ptr);
    assign w_pick_rel  = rr_pick(req, w_ptr_after);

    always_comb begin
        r_state_next = r_state;
        r_sel_next   = r_sel;
        r_gnt_next   = r_gnt;
        r_ptr_next   = r_ptr;
        r_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle.found) begin
                    r_state_next = ST_GRANT;
                    r_sel_next   = w_pick_idle.idx;
                    r_gnt_next   = NUM_REQ'(1) << w_pick_idle.idx;
                    r_cnt_next   = '0;
                end
            end
            ST_GRANT: begin
                if (w_release) begin
                    r_ptr_next = w_ptr_after;
                    r_cnt_next = '0;
                    if (w_pick_rel.found) begin
                        r_sel_next = w_pick_rel.idx;
                        r_gnt_next = NUM_REQ'(1) << w_pick_rel.idx;
                    end else begin
                        // sel keeps the last owner while idle
                        r_state_next = ST_IDLE;
                        r_gnt_next   = '0;
                    end
                end else if (w_xfer) begin
                    r_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                r_state_next = ST_IDLE;
                r_gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= r_state_next;
            r_sel   <= r_sel_next;
            r_gnt   <= r_gnt_next;
            r_ptr   <= r_ptr_next;
            r_cnt   <= r_cnt_next;
        end
    end

    mux4 #(
        .WIDTH (WIDTH)
    ) u_mux4 (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (r_sel),
        .out (out_data)
    );

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign busy      = w_busy;
    assign out_valid = w_valid;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus a randomized run, all checked
// against a behavioural model that tracks owner, pointer and beat count as integers.
module tb_mux4_rr_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = 4'b0;
    logic [W-1:0] d [4];
    logic         out_ready = 1'b0;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    int m_busy  = 0;
    int m_owner = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in0       (d[0]),
        .in1       (d[1]),
        .in2       (d[2]),
        .in3       (d[3]),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    function automatic int first_from(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt();
        return m_busy != 0 ? 4'(1 << m_owner) : 4'b0;
    endfunction

    // Reference behaviour for one clock edge given the inputs present at that edge.
    task automatic model_step(input logic [3:0] r, input logic rd, input logic rs);
        bit beat;
        if (!rs) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_busy == 0) begin
            if (r != 4'b0) begin
                m_owner = first_from(r, m_ptr);
                m_busy  = 1;
                m_cnt   = 0;
            end
        end else begin
            beat = r[m_owner] && rd;
            if (!r[m_owner] || (beat && m_cnt == MB - 1)) begin
                m_ptr = (m_owner + 1) % 4;
                m_cnt = 0;
                if (r != 4'b0) m_owner = first_from(r, m_ptr);
                else m_busy = 0;
            end else if (beat) begin
                m_cnt++;
            end
        end
    endtask

    // Drive one cycle of inputs (fresh random data), step the model, park on the falling edge.
    task automatic cycle(input logic [3:0] r, input logic rd, input logic rs);
        req = r; out_ready = rd; rst_n = rs;
        for (int k = 0; k < 4; k++) d[k] = W'($urandom);
        @(posedge clk);
        model_step(r, rd, rs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(4'b1111, 1'b1, 1'b0);
        cycle(4'b1111, 1'b1, 1'b0);
        n_tests++;
        if (gnt !== 4'b0 || busy !== 1'b0 || out_valid !== 1'b0 || sel !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: gnt=%b busy=%b valid=%b sel=%0d expected 0000/0/0/0",
                     gnt, busy, out_valid, sel);
        end
        n_tests++;
        if (out_data !== d[0]) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h expected %h", out_data, d[0]);
        end
        cycle(4'b1111, 1'b1, 1'b1);
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: gnt=%b expected 0001", gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        for (int k = 0; k <= 16; k++) begin
            want = 4'(1 << ((k / 4) % 4));
            n_tests++;
            if (gnt !== want || busy !== 1'b1 || out_valid !== 1'b1 || out_data !== d[(k / 4) % 4]) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: gnt=%b busy=%b valid=%b data=%h expected %b/1/1/%h",
                         k, gnt, busy, out_valid, out_data, want, d[(k / 4) % 4]);
            end
            if (k < 16) cycle(4'b1111, 1'b1, 1'b1);
        end
    endtask

    task automatic test_early_release();
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b1);
        cycle(4'b0101, 1'b1, 1'b1);
        n_tests++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL early_owner2: gnt=%b expected 0100", gnt);
        end
        cycle(4'b0001, 1'b1, 1'b1);
        n_tests++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL early_regrant: gnt=%b sel=%0d busy=%b expected 0001/0/1", gnt, sel, busy);
        end
        // A fresh count for owner 0 means three beats keep the grant and the fourth hands it to 1.
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0011, 1'b1, 1'b1);
            n_tests++;
            if (gnt !== (k < 3 ? 4'b0001 : 4'b0010)) begin
                n_fail++;
                $display("FAIL early_cnt_reset[%0d]: gnt=%b expected %b", k, gnt,
                         (k < 3 ? 4'b0001 : 4'b0010));
            end
        end
    endtask

    task automatic test_backpressure();
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0010, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (gnt !== 4'b0010 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: gnt=%b valid=%b expected 0010/1", k, gnt, out_valid);
            end
            cycle(4'b0010, 1'b0, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            cycle(4'b0011, 1'b1, 1'b1);
            n_tests++;
            if (gnt !== (k < 3 ? 4'b0010 : 4'b0001)) begin
                n_fail++;
                $display("FAIL backpressure_beats[%0d]: gnt=%b expected %b", k, gnt,
                         (k < 3 ? 4'b0010 : 4'b0001));
            end
        end
        // Lone requester: regranted immediately after its burst.
        cycle(4'b0000, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) cycle(4'b0010, 1'b1, 1'b1);
        n_tests++;
        if (gnt !== 4'b0010 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_regrant: gnt=%b busy=%b expected 0010/1", gnt, busy);
        end
    endtask

    task automatic test_idle_return();
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b0100, 1'b1, 1'b1);
        cycle(4'b0100, 1'b1, 1'b1);
        cycle(4'b0000, 1'b1, 1'b1);
        n_tests++;
        if (busy !== 1'b0 || gnt !== 4'b0 || sel !== 2'd2 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_return: busy=%b gnt=%b sel=%0d valid=%b expected 0/0000/2/0",
                     busy, gnt, sel, out_valid);
        end
        cycle(4'b0000, 1'b1, 1'b1);
        cycle(4'b1000, 1'b1, 1'b1);
        n_tests++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            n_fail++;
            $display("FAIL idle_regrant: gnt=%b sel=%0d expected 1000/3", gnt, sel);
        end
    endtask

    task automatic test_reset_mid_burst();
        cycle(4'b0000, 1'b1, 1'b0);
        cycle(4'b1000, 1'b1, 1'b1);
        cycle(4'b1000, 1'b1, 1'b1);
        cycle(4'b1000, 1'b1, 1'b1);
        cycle(4'b1000, 1'b1, 1'b0);
        n_tests++;
        if (gnt !== 4'b0 || busy !== 1'b0 || sel !== 2'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_burst_reset: gnt=%b busy=%b sel=%0d valid=%b expected 0000/0/0/0",
                     gnt, busy, sel, out_valid);
        end
        cycle(4'b1001, 1'b1, 1'b1);
        n_tests++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_burst_resume: gnt=%b expected 0001", gnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] r;
        cycle(4'b0000, 1'b1, 1'b0);
        r = 4'b0;
        for (int k = 0; k < 600; k++) begin
            r = r ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            cycle(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) != 0));
            n_tests++;
            if (gnt !== exp_gnt() || sel !== m_owner[1:0] || busy !== (m_busy != 0)
                || out_valid !== (m_busy != 0 && req[m_owner]) || out_data !== d[m_owner]) begin
                n_fail++;
                $display("FAIL random[%0d]: gnt=%b sel=%0d busy=%b valid=%b data=%h expected %b/%0d/%0d/%0d/%h",
                         k, gnt, sel, busy, out_valid, out_data, exp_gnt(), m_owner, m_busy,
                         (m_busy != 0 && req[m_owner]), d[m_owner]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) d[k] = '0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_early_release();
        test_backpressure();
        test_idle_return();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
